data_mem_responder: RTL and testbench

//  Memory-side responder for CPU data-bus requests in the MIPS32 SoC.

---
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-bus responder mapping the global and stack windows onto a 2048x32 word RAM.
// Optional build macro FAULT_LATCH_EN adds a sticky first-fault address capture (faultValid/faultAddr/faultClr).
module data_mem_responder #(
   parameter logic [31:0] GLOBAL_BASE = 32'h1001_0000,
   parameter logic [31:0] GLOBAL_END  = 32'h1001_1000,
   parameter logic [31:0] STACK_BASE  = 32'h7FFF_EFFC,
   parameter logic [31:0] STACK_END   = 32'h7FFF_FFFC,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWdata,
   input  logic [3:0]  reqBe,
   output logic        rspValid,
   input  logic        rspReady,
   output logic [31:0] rspRdata,
   output logic        rspErr,
`ifdef FAULT_LATCH_EN
   output logic        faultValid,
   output logic [31:0] faultAddr,
   input  logic        faultClr,
`endif
   output logic [1:0]  dbg_state
);

   // Handshakes: a beat transfers on a rising edge where valid and ready are both 1; a valid
   // source holds its payload until that edge, and ready may not depend on the payload.
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic        ready_q;
   logic        wr_q, err_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [10:0] idx_q;
   logic [31:0] mem [0:2047];

   logic        accept, in_global, in_stack, dec_err, access;
   logic [9:0]  goff, soff;
   logic [10:0] dec_idx;

   assign accept    = reqValid & ready_q;
   assign reqReady  = ready_q;
   assign dbg_state = state;

   always_comb begin
      in_global = (reqAddr >= GLOBAL_BASE) && (reqAddr < GLOBAL_END);
      in_stack  = (reqAddr >= STACK_BASE) && (reqAddr < STACK_END);
      dec_err   = !(in_global || in_stack) || (reqAddr[1:0] != 2'b00);
      goff      = reqAddr[11:2] - GLOBAL_BASE[11:2];
      soff      = reqAddr[11:2] - STACK_BASE[11:2];
      dec_idx   = in_stack ? {1'b1, soff} : {1'b0, goff};
   end

   always_comb begin
      state_nx = state;
      rspValid = 1'b0;
      access   = 1'b0;
      unique case (state)
         IDLE: if (accept) state_nx = WAIT;
         WAIT: begin
            // Errors also pass through WAIT with a zero count so they answer one cycle after accept.
            if (cnt == 4'd0) begin
               state_nx = RESP;
               access   = !err_q;
            end
         end
         RESP: begin
            rspValid = 1'b1;
            if (rspReady) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q  <= 1'b0;
         cnt      <= 4'd0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         wdata_q  <= 32'h0;
         be_q     <= 4'h0;
         idx_q    <= 11'd0;
         rspRdata <= 32'h0;
         rspErr   <= 1'b0;
      end else begin
         ready_q <= (state_nx == IDLE);
         if (accept) begin
            wr_q    <= reqWrite;
            wdata_q <= reqWdata;
            be_q    <= reqBe;
            idx_q   <= dec_idx;
            err_q   <= dec_err;
            cnt     <= dec_err ? 4'd0 : 4'(WAIT_CYCLES);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state == WAIT && cnt == 4'd0) begin
            rspErr   <= err_q;
            rspRdata <= (err_q || wr_q) ? 32'h0 : mem[idx_q];
         end
      end
   end

   // RAM contents survive reset; access is gated by the reset-cleared state so aborted stores never land.
   always_ff @(posedge clk) begin
      if (access && wr_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

`ifdef FAULT_LATCH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         faultValid <= 1'b0;
         faultAddr  <= 32'h0;
      end else if (faultClr) begin
         faultValid <= 1'b0;
         faultAddr  <= 32'h0;
      end else if (accept && dec_err && !faultValid) begin
         faultValid <= 1'b1;
         faultAddr  <= reqAddr;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder with WAIT_CYCLES=3.
// Fault-latch checks are compiled in when FAULT_LATCH_EN is defined.
module tb_data_mem_responder;
   localparam int WC = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reqValid = 1'b0, reqWrite = 1'b0;
   logic [31:0] reqAddr = 32'h0, reqWdata = 32'h0;
   logic [3:0]  reqBe = 4'h0;
   logic        rspReady = 1'b0;
   logic        reqReady, rspValid, rspErr;
   logic [31:0] rspRdata;
   logic [1:0]  dbg_state;
`ifdef FAULT_LATCH_EN
   logic        faultValid, faultClr = 1'b0;
   logic [31:0] faultAddr;
`endif

   logic [32:0] exp_q[$];
   logic [31:0] model [0:2047];
   int n_cmp = 0;
   int n_bad = 0;

   data_mem_responder #(.WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst_n(rst_n),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqAddr(reqAddr), .reqWdata(reqWdata), .reqBe(reqBe),
      .rspValid(rspValid), .rspReady(rspReady), .rspRdata(rspRdata), .rspErr(rspErr),
`ifdef FAULT_LATCH_EN
      .faultValid(faultValid), .faultAddr(faultAddr), .faultClr(faultClr),
`endif
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int map_idx(input logic [31:0] a);
      if (a[1:0] != 2'b00) return -1;
      if (a >= 32'h10010000 && a < 32'h10011000) return int'((a - 32'h10010000) >> 2);
      if (a >= 32'h7FFFEFFC && a < 32'h7FFFFFFC) return 1024 + int'((a - 32'h7FFFEFFC) >> 2);
      return -1;
   endfunction

   // One full transaction: model, push expectation, drive, check latency/hold, pop and compare.
   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
      int idx, lat, exp_lat, n;
      logic [32:0] exp, held;
      idx = map_idx(addr);
      if (idx < 0) begin
         exp = {1'b1, 32'h0};
         exp_lat = 1;
      end else begin
         exp_lat = 1 + WC;
         if (wr) begin
            exp = 33'h0;
            for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
         end else begin
            exp = {1'b0, model[idx]};
         end
      end
      exp_q.push_back(exp);
      reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wd; reqBe = be;
      n = 0;
      while (reqReady !== 1'b1 && n < 50) begin step(); n++; end
      chk("req_ready", reqReady, 1);
      step();
      reqValid = 1'b0;
      reqWrite = 1'($urandom_range(0, 1));
      reqAddr  = $urandom;
      reqWdata = $urandom;
      reqBe    = 4'($urandom_range(0, 15));
      chk("ready_low_busy", reqReady, 0);
      lat = 0;
      do begin step(); lat++; end while (rspValid !== 1'b1 && lat < 40);
      chk("latency", lat, exp_lat);
      held = {rspErr, rspRdata};
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", rspValid, 1);
         chk("hold_data", {rspErr, rspRdata}, held);
         chk("hold_ready", reqReady, 0);
      end
      rspReady = 1'b1;
      chk("rsp_data", {rspErr, rspRdata}, exp_q.pop_front());
      step();
      rspReady = 1'b0;
      chk("valid_drop", rspValid, 0);
   endtask

   initial begin
      logic [31:0] a;
      int n;
      foreach (model[i]) model[i] = 'x;

      // Reset state
      step(); step();
      chk("rst_valid", rspValid, 0);
      chk("rst_err", rspErr, 0);
      chk("rst_rdata", rspRdata, 0);
      chk("rst_ready", reqReady, 0);
      chk("rst_state", dbg_state, 0);
`ifdef FAULT_LATCH_EN
      chk("rst_fault_valid", faultValid, 0);
      chk("rst_fault_addr", faultAddr, 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("ready_after_rst", reqReady, 1);

      // Basic store / load
      send(1'b1, 32'h10010000, 32'hDEADBEEF, 4'hF, 0);
      send(1'b0, 32'h10010000, 32'h0, 4'h0, 0);

      // Byte lanes on the top stack word
      send(1'b1, 32'h7FFFFFF8, 32'h0, 4'hF, 0);
      send(1'b1, 32'h7FFFFFF8, 32'h11223344, 4'b0101, 0);
      send(1'b0, 32'h7FFFFFF8, 32'h0, 4'hF, 0);

      // Errors, including a store that must not write
      send(1'b0, 32'h10011000, 32'h0, 4'h0, 0);
      send(1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, 0);
      send(1'b0, 32'h00400000, 32'h0, 4'h0, 0);
      send(1'b0, 32'h10010002, 32'h0, 4'h0, 0);
      send(1'b1, 32'h10010001, 32'h55555555, 4'hF, 0);
      send(1'b0, 32'h10010000, 32'h0, 4'h0, 0);

      // Window edges, with a held response
      send(1'b1, 32'h10010FFC, 32'hA5A5_0FFC, 4'hF, 0);
      send(1'b1, 32'h7FFFEFFC, 32'h5A5A_EFFC, 4'hF, 0);
      send(1'b0, 32'h10010FFC, 32'h0, 4'h0, 5);
      send(1'b0, 32'h7FFFEFFC, 32'h0, 4'h0, 2);

      // be=0 store leaves the word alone
      send(1'b1, 32'h10010000, 32'h01234567, 4'h0, 0);
      send(1'b0, 32'h10010000, 32'h0, 4'h0, 0);

      // Reset during WAIT aborts a store
      send(1'b1, 32'h10010004, 32'hCAFEF00D, 4'hF, 0);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h10010004; reqWdata = 32'h0BADBAD0; reqBe = 4'hF;
      step();
      reqValid = 1'b0;
      chk("abort_in_wait", dbg_state, 1);
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("abort_valid", rspValid, 0);
      chk("abort_state", dbg_state, 0);
      step(); step();
      @(negedge clk) rst_n = 1'b1;
      step();
      send(1'b0, 32'h10010004, 32'h0, 4'h0, 0);

      // Random global-window words: full write, partial write, load
      for (int k = 0; k < 6; k++) begin
         a = 32'h10010000 + (32'($urandom_range(8, 1022)) << 2);
         send(1'b1, a, $urandom, 4'hF, 0);
         send(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 0);
         send(1'b0, a, 32'h0, 4'h0, $urandom_range(0, 2));
      end

`ifdef FAULT_LATCH_EN
      faultClr = 1'b1;
      step();
      faultClr = 1'b0;
      chk("fault_clear0", faultValid, 0);
      chk("fault_clear0_addr", faultAddr, 0);
      send(1'b0, 32'h00000000, 32'h0, 4'h0, 0);
      send(1'b0, 32'h00000004, 32'h0, 4'h0, 0);
      chk("fault_valid", faultValid, 1);
      chk("fault_first_addr", faultAddr, 32'h0);
      faultClr = 1'b1;
      step();
      faultClr = 1'b0;
      chk("fault_clr", faultValid, 0);
      faultClr = 1'b1; reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h00000008;
      step();
      faultClr = 1'b0; reqValid = 1'b0;
      chk("fault_same_edge", faultValid, 0);
      n = 0;
      while (rspValid !== 1'b1 && n < 20) begin step(); n++; end
      chk("same_edge_err", rspErr, 1);
      rspReady = 1'b1;
      step();
      rspReady = 1'b0;
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
